// File: rtl/sram_dp_be_pkg.sv
// Shared types and constants for the simple-dual-port byte-enable SRAM model.
package sram_dp_be_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } init_state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_dp_be_if.sv
// Write/read port bundle of the SRAM model; master drives requests, slave returns read data.
interface sram_dp_be_if
  import sram_dp_be_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
);
  localparam int ADDR_W = addr_w(DEPTH);
  localparam int BE_W   = DATA_W / 8;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [BE_W-1:0]   wr_be;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              init_done;

  modport master (
    output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  rd_valid, rd_data, init_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output rd_valid, rd_data, init_done
  );

endinterface

// File: rtl/sram_dp_be_init_fsm.sv
// Post-reset init engine: sweeps a pointer over every word, then parks in READY until the next reset.
module sram_dp_be_init_fsm
  import sram_dp_be_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_init_we,
  output logic [ADDR_W-1:0] o_init_addr,
  output logic              o_init_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  init_state_e       r_state;
  init_state_e       w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT && r_ptr != LAST) r_ptr <= r_ptr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_ptr == LAST) w_state_nxt = ST_READY;
  end

  always_comb begin
    o_init_we   = (r_state == ST_INIT);
    o_init_addr = r_ptr;
    o_init_done = (r_state == ST_READY);
  end

endmodule

// File: rtl/sram_dp_be.sv
// Simple-dual-port synchronous SRAM model with byte enables, selectable read latency,
// selectable read-during-write policy and a fill-on-reset init engine.
module sram_dp_be
  import sram_dp_be_pkg::*;
#(
  parameter int               DATA_W   = 32,
  parameter int               DEPTH    = 1024,
  parameter int               RD_LAT   = 1,
  parameter int               RDW_MODE = RDW_OLD,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  sram_dp_be_if.slave  bus
);

  localparam int              ADDR_W  = addr_w(DEPTH);
  localparam int              BE_W    = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("sram_dp_be: RD_LAT must be 1 or 2");
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("sram_dp_be: DATA_W must be a multiple of 8");
  end
  if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
    $error("sram_dp_be: RDW_MODE must be 0 or 1");
  end

  function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_w,
                                                 input logic [DATA_W-1:0] new_w,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] m;
    m = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_init_we;
  logic [ADDR_W-1:0] w_init_addr;
  logic              w_init_done;
  logic              w_port_act;
  logic              w_wr_ok;
  logic              w_rd_fire;
  logic              w_rd_inr;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [BE_W-1:0]   w_wbe;
  logic [DATA_W-1:0] w_rd_word;
  logic              r_vld_p1;
  logic [DATA_W-1:0] r_data_p1;

  sram_dp_be_init_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_fsm (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .o_init_we   (w_init_we),
    .o_init_addr (w_init_addr),
    .o_init_done (w_init_done)
  );

  // Ports are dead during INIT and on any reset edge, so a reset cannot leak a port write.
  assign w_port_act = w_init_done & rst_n;
  assign w_wr_ok    = w_port_act & bus.wr_en & ({1'b0, bus.wr_addr} < DEPTH_C);
  assign w_rd_fire  = w_port_act & bus.rd_en;
  assign w_rd_inr   = ({1'b0, bus.rd_addr} < DEPTH_C);

  always_comb begin
    w_we    = 1'b0;
    w_waddr = bus.wr_addr;
    w_wdata = bus.wr_data;
    w_wbe   = bus.wr_be;
    if (w_init_we) begin
      w_we    = 1'b1;
      w_waddr = w_init_addr;
      w_wdata = INIT_VAL;
      w_wbe   = '1;
    end else if (w_wr_ok) begin
      w_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= merge_be(r_mem[w_waddr], w_wdata, w_wbe);
  end

  // Array read sees the pre-write word; new-data mode overlays the colliding write bytes.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_inr) begin
      w_rd_word = r_mem[bus.rd_addr];
      if (RDW_MODE == RDW_NEW && w_wr_ok && bus.wr_addr == bus.rd_addr)
        w_rd_word = merge_be(w_rd_word, bus.wr_data, bus.wr_be);
    end
  end

  // Stage p1: array read captured
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
    end else begin
      r_vld_p1 <= w_rd_fire;
      if (w_rd_fire) r_data_p1 <= w_rd_word;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              r_vld_p2;
    logic [DATA_W-1:0] r_data_p2;

    // Stage p2: output register
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_vld_p2  <= 1'b0;
        r_data_p2 <= '0;
      end else begin
        r_vld_p2 <= r_vld_p1;
        if (r_vld_p1) r_data_p2 <= r_data_p1;
      end
    end

    assign bus.rd_valid = r_vld_p2;
    assign bus.rd_data  = r_data_p2;
  end else begin : g_lat1
    assign bus.rd_valid = r_vld_p1;
    assign bus.rd_data  = r_data_p1;
  end

  assign bus.init_done = w_init_done;

endmodule

// File: tb/tb_sram_dp_be.sv
// Scoreboard bench: two instances driven in lockstep (A: 1024 words, RD_LAT=1, old-data;
// B: 1000 words, RD_LAT=2, new-data, nonzero INIT_VAL), each with its own expected-read queue.
module tb_sram_dp_be;

  localparam logic [31:0] INIT_B = 32'hA5A5_0F0F;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [9:0]  rd_addr = '0;

  int   cyc = 0;
  int   n_tot = 0;
  int   n_pass = 0;
  int   nva = 0;
  int   nvb = 0;
  exp_t qa[$];
  exp_t qb[$];

  sram_dp_be_if #(.DATA_W(32), .DEPTH(1024)) ifa ();
  sram_dp_be_if #(.DATA_W(32), .DEPTH(1000)) ifb ();

  assign ifa.wr_en = wr_en;   assign ifb.wr_en = wr_en;
  assign ifa.wr_addr = wr_addr; assign ifb.wr_addr = wr_addr;
  assign ifa.wr_be = wr_be;   assign ifb.wr_be = wr_be;
  assign ifa.wr_data = wr_data; assign ifb.wr_data = wr_data;
  assign ifa.rd_en = rd_en;   assign ifb.rd_en = rd_en;
  assign ifa.rd_addr = rd_addr; assign ifb.rd_addr = rd_addr;

  sram_dp_be #(
    .DATA_W(32), .DEPTH(1024), .RD_LAT(1), .RDW_MODE(0), .INIT_VAL(32'h0)
  ) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  sram_dp_be #(
    .DATA_W(32), .DEPTH(1000), .RD_LAT(2), .RDW_MODE(1), .INIT_VAL(INIT_B)
  ) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tot++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp_v, cyc);
  endtask

  // Monitors: pop on every rd_valid, flag unexpected or overdue responses.
  always @(negedge clk) begin
    exp_t e;
    if (ifa.rd_valid) begin
      nva++;
      if (qa.size() == 0) begin
        n_tot++;
        $display("FAIL a_unexpected_valid got=%h want=no_valid (cycle %0d)", ifa.rd_data, cyc);
      end else begin
        e = qa.pop_front();
        check("a_rd_data", ifa.rd_data, e.d);
        check("a_rd_cycle", cyc, e.c);
      end
    end else if (qa.size() != 0 && qa[0].c <= cyc) begin
      e = qa.pop_front();
      n_tot++;
      $display("FAIL a_missing_valid got=none want=%h (cycle %0d)", e.d, cyc);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ifb.rd_valid) begin
      nvb++;
      if (qb.size() == 0) begin
        n_tot++;
        $display("FAIL b_unexpected_valid got=%h want=no_valid (cycle %0d)", ifb.rd_data, cyc);
      end else begin
        e = qb.pop_front();
        check("b_rd_data", ifb.rd_data, e.d);
        check("b_rd_cycle", cyc, e.c);
      end
    end else if (qb.size() != 0 && qb[0].c <= cyc) begin
      e = qb.pop_front();
      n_tot++;
      $display("FAIL b_missing_valid got=none want=%h (cycle %0d)", e.d, cyc);
    end
  end

  // One edge of stimulus; a read pushes the expected word for each instance with its latency.
  task automatic xfer(input bit we, input logic [9:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input bit re, input logic [9:0] ra,
                      input logic [31:0] ea, input logic [31:0] eb);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
    if (re) begin
      qa.push_back('{ea, cyc + 1});
      qb.push_back('{eb, cyc + 2});
    end
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    xfer(1'b1, a, d, be, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] ea, input logic [31:0] eb);
    xfer(1'b0, '0, '0, '0, 1'b1, a, ea, eb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Counts edges from reset release to init_done; optionally hammers the ports while initialising.
  task automatic wait_init(input bit poke, output int la, output int lb);
    la = 0;
    lb = 0;
    for (int k = 1; k <= 1100 && (la == 0 || lb == 0); k++) begin
      if (poke) begin
        wr_en = (k < 900); wr_addr = 10'h010; wr_data = 32'h1234_5678; wr_be = 4'hF;
        rd_en = (k < 900); rd_addr = 10'h010;
      end
      @(negedge clk);
      if (la == 0 && ifa.init_done) la = k;
      if (lb == 0 && ifb.init_done) lb = k;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    int la, lb, nva0, nvb0;

    // Reset state
    idle(3);
    check("a_rst_init_done", 32'(ifa.init_done), 32'd0);
    check("b_rst_init_done", 32'(ifb.init_done), 32'd0);
    check("a_rst_rd_valid", 32'(ifa.rd_valid), 32'd0);
    check("b_rst_rd_valid", 32'(ifb.rd_valid), 32'd0);
    check("a_rst_rd_data", ifa.rd_data, 32'd0);
    check("b_rst_rd_data", ifb.rd_data, 32'd0);

    // Init sweep timing and fill value
    rst_n = 1'b1;
    wait_init(1'b0, la, lb);
    check("a_init_latency", 32'(la), 32'd1024);
    check("b_init_latency", 32'(lb), 32'd1000);
    rd(10'h3FF, 32'h0, 32'h0);
    rd(10'h000, 32'h0, INIT_B);
    rd(10'd999, 32'h0, INIT_B);

    // Byte-enable write
    wr(10'h010, 32'hDEAD_BEEF, 4'hF);
    wr(10'h010, 32'h0000_5500, 4'b0010);
    rd(10'h010, 32'hDEAD_55EF, 32'hDEAD_55EF);

    // Same-address collision, then write one edge after a read
    wr(10'd5, 32'h1111_1111, 4'hF);
    xfer(1'b1, 10'd5, 32'h2222_2222, 4'b0001, 1'b1, 10'd5, 32'h1111_1111, 32'h1111_1122);
    rd(10'd5, 32'h1111_1122, 32'h1111_1122);
    wr(10'd5, 32'h3333_3333, 4'hF);
    rd(10'd5, 32'h3333_3333, 32'h3333_3333);

    // Back-to-back reads, different-address write alongside, zero byte-enable
    wr(10'd1, 32'hA1A1_A1A1, 4'hF);
    wr(10'd2, 32'hB2B2_B2B2, 4'hF);
    wr(10'd3, 32'hC3C3_C3C3, 4'hF);
    xfer(1'b1, 10'd6, 32'h6666_6666, 4'hF, 1'b1, 10'd1, 32'hA1A1_A1A1, 32'hA1A1_A1A1);
    rd(10'd2, 32'hB2B2_B2B2, 32'hB2B2_B2B2);
    rd(10'd3, 32'hC3C3_C3C3, 32'hC3C3_C3C3);
    idle(5);
    check("a_rd_data_hold", ifa.rd_data, 32'hC3C3_C3C3);
    check("b_rd_data_hold", ifb.rd_data, 32'hC3C3_C3C3);
    wr(10'd6, 32'h0000_0000, 4'h0);
    rd(10'd6, 32'h6666_6666, 32'h6666_6666);

    // Address 1000: in range for A, out of range for B
    wr(10'd1000, 32'hFFFF_FFFF, 4'hF);
    rd(10'd1000, 32'hFFFF_FFFF, 32'h0);
    rd(10'd999, 32'h0, INIT_B);
    idle(4);

    // Reset with reads in flight, then port activity during INIT
    nva0 = nva;
    nvb0 = nvb;
    rd_en = 1'b1;
    rd_addr = 10'h010;
    qa.push_back('{32'hDEAD_55EF, cyc + 1});
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rd_en = 1'b0;
    idle(3);
    check("a_valid_count_at_reset", 32'(nva - nva0), 32'd1);
    check("b_inflight_dropped", 32'(nvb - nvb0), 32'd0);
    check("a_reinit_done_low", 32'(ifa.init_done), 32'd0);
    check("b_reinit_done_low", 32'(ifb.init_done), 32'd0);
    check("b_reinit_rd_data", ifb.rd_data, 32'd0);
    rst_n = 1'b1;
    wait_init(1'b1, la, lb);
    check("a_reinit_latency", 32'(la), 32'd1024);
    check("b_reinit_latency", 32'(lb), 32'd1000);
    check("a_no_valid_in_init", 32'(nva - nva0), 32'd1);
    check("b_no_valid_in_init", 32'(nvb - nvb0), 32'd0);
    rd(10'h010, 32'h0, INIT_B);
    rd(10'd5, 32'h0, INIT_B);
    rd(10'd1000, 32'h0, 32'h0);
    idle(5);
    check("a_queue_drained", 32'(qa.size()), 32'd0);
    check("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
